// File: rtl/collatz_seq_ctrl.sv
// rtl/collatz_seq_ctrl.sv - Collatz sequence walker with step, peak and status reporting
module collatz_seq_ctrl #(
    parameter int VAL_W = 16,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic [1:0] sel,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ZERO    = 2'b01;
    localparam logic [1:0] STAT_OVF     = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    // Width of the peak slice shown on the high byte view
    localparam int HI_W = (VAL_W > 16) ? 8 : ((VAL_W > 8) ? (VAL_W - 8) : 1);

    state_t             state, state_nxt;
    logic [VAL_W-1:0]   value, value_nxt;
    logic [CNT_W-1:0]   step_count, count_nxt;
    logic [VAL_W-1:0]   peak, peak_nxt;
    logic [1:0]         status_q, status_nxt;

    logic [VAL_W-1:0]   seed_ext;
    logic [VAL_W+1:0]   value_wide;
    logic [VAL_W+1:0]   triple;
    logic [VAL_W-1:0]   step_val;
    logic               step_commit;
    logic [7:0]         count_ext;
    logic [7:0]         peak_hi;

    // Zero-extend the 8-bit seed into the working width
    always_comb begin
        seed_ext      = '0;
        seed_ext[7:0] = seed;
    end

    // 3*value+1 with two guard bits so any carry out of VAL_W is visible
    always_comb begin
        value_wide = {2'b00, value};
        triple     = (value_wide << 1) + value_wide + {{(VAL_W+1){1'b0}}, 1'b1};
    end

    // Next-state and datapath decision for one enabled edge
    always_comb begin
        state_nxt   = state;
        value_nxt   = value;
        count_nxt   = step_count;
        peak_nxt    = peak;
        status_nxt  = status_q;
        step_val    = value;
        step_commit = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    value_nxt  = seed_ext;
                    count_nxt  = '0;
                    peak_nxt   = seed_ext;
                    status_nxt = STAT_OK;
                end
            end
            ST_RUN: begin
                if (value == '0) begin
                    state_nxt  = ST_DONE;
                    status_nxt = STAT_ZERO;
                end else if (value == {{(VAL_W-1){1'b0}}, 1'b1}) begin
                    state_nxt  = ST_DONE;
                    status_nxt = STAT_OK;
                end else if (&step_count) begin
                    // Step budget exhausted; checked before the overflow test
                    state_nxt  = ST_DONE;
                    status_nxt = STAT_TIMEOUT;
                end else if (!value[0]) begin
                    step_val    = value >> 1;
                    step_commit = 1'b1;
                end else if (triple[VAL_W+1:VAL_W] != 2'b00) begin
                    state_nxt  = ST_DONE;
                    status_nxt = STAT_OVF;
                end else begin
                    step_val    = triple[VAL_W-1:0];
                    step_commit = 1'b1;
                end

                if (step_commit) begin
                    value_nxt = step_val;
                    count_nxt = step_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    peak_nxt  = (step_val > peak) ? step_val : peak;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; ena low freezes the whole machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Datapath registers follow the same enable as the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value      <= '0;
            step_count <= '0;
            peak       <= '0;
            status_q   <= STAT_OK;
        end else if (ena) begin
            value      <= value_nxt;
            step_count <= count_nxt;
            peak       <= peak_nxt;
            status_q   <= status_nxt;
        end
    end

    // Status flags decoded straight from the state register
    always_comb begin
        busy   = (state == ST_RUN);
        done   = (state == ST_DONE);
        status = status_q;
    end

    // Step count zero-extended to a byte
    always_comb begin
        count_ext               = '0;
        count_ext[CNT_W-1:0]    = step_count;
    end

    generate
        if (VAL_W > 8) begin : g_peak_hi
            // Peak bits 15:8, truncated for wide values, zero-padded for narrow ones
            always_comb begin
                peak_hi           = '0;
                peak_hi[HI_W-1:0] = peak[8+HI_W-1:8];
            end
        end else begin : g_peak_hi_zero
            // No upper peak byte exists at this width
            always_comb begin
                peak_hi = '0;
            end
        end
    endgenerate

    // Result view multiplexer
    always_comb begin
        dout = 8'h00;
        case (sel)
            2'd0:    dout = count_ext;
            2'd1:    dout = peak[7:0];
            2'd2:    dout = peak_hi;
            default: dout = {busy, done, status_q, 4'b0000};
        endcase
    end

endmodule

// File: tb/tb_collatz_seq_ctrl.sv
// tb/tb_collatz_seq_ctrl.sv - directed self-checking bench for collatz_seq_ctrl
module tb_collatz_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] seed;
    logic [1:0] sel;
    logic       start_a, start_b, start_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [1:0] status_a, status_b, status_c;

    int checks = 0;
    int errors = 0;

    collatz_seq_ctrl #(.VAL_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_a), .seed(seed), .sel(sel),
        .dout(dout_a), .busy(busy_a), .done(done_a), .status(status_a)
    );

    collatz_seq_ctrl #(.VAL_W(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .seed(seed), .sel(sel),
        .dout(dout_b), .busy(busy_b), .done(done_b), .status(status_b)
    );

    collatz_seq_ctrl #(.VAL_W(16), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_c), .seed(seed), .sel(sel),
        .dout(dout_c), .busy(busy_c), .done(done_c), .status(status_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_done(input int d);
        return (d == 0) ? done_a : (d == 1) ? done_b : done_c;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v;
        else if (d == 1) start_b = v;
        else start_c = v;
    endtask

    task automatic read_views(input int d, output logic [7:0] cnt, output logic [7:0] lo,
                              output logic [7:0] hi, output logic [7:0] s3);
        sel = 2'd0; #1; cnt = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
        sel = 2'd1; #1; lo  = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
        sel = 2'd2; #1; hi  = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
        sel = 2'd3; #1; s3  = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
    endtask

    task automatic start_pulse(input int d, input logic [7:0] s);
        @(negedge clk);
        seed = s;
        set_start(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    task automatic wait_done(input int d, output int edges);
        edges = 0;
        while (!get_done(d) && edges < 2000) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        checks++;
        if (!get_done(d)) begin
            errors++;
            $display("FAIL wait_done dut%0d: done never rose within %0d edges", d, edges);
        end
    endtask

    task automatic test_reset;
        logic [7:0] c, l, h, s;
        rst_n = 1'b0; ena = 1'b1; seed = 8'd0; sel = 2'd0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        #12;
        read_views(0, c, l, h, s);
        checks++; if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {busy_a, done_a}); end
        checks++; if (c !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", c); end
        checks++; if (l !== 8'd0) begin errors++; $display("FAIL reset_peak: got %0d want 0", l); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_view3: got %h want 00", s); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seed6;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd6);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL seed6_busy: got %b want 1", busy_a); end
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 9) begin errors++; $display("FAIL seed6_edges: got %0d want 9", e); end
        checks++; if (c !== 8'd8) begin errors++; $display("FAIL seed6_count: got %0d want 8", c); end
        checks++; if (l !== 8'd16 || h !== 8'd0) begin errors++; $display("FAIL seed6_peak: got %h%h want 0010", h, l); end
        checks++; if (s !== 8'h40) begin errors++; $display("FAIL seed6_view3: got %h want 40", s); end
    endtask

    task automatic test_back_to_back;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd7);
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 17) begin errors++; $display("FAIL seed7_edges: got %0d want 17", e); end
        checks++; if (c !== 8'd16) begin errors++; $display("FAIL seed7_count: got %0d want 16", c); end
        checks++; if (l !== 8'd52) begin errors++; $display("FAIL seed7_peak: got %0d want 52", l); end
    endtask

    task automatic test_seed27;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd27);
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 112) begin errors++; $display("FAIL seed27_edges: got %0d want 112", e); end
        checks++; if (c !== 8'd111) begin errors++; $display("FAIL seed27_count: got %0d want 111", c); end
        checks++; if (l !== 8'h10) begin errors++; $display("FAIL seed27_peak_lo: got %h want 10", l); end
        checks++; if (h !== 8'h24) begin errors++; $display("FAIL seed27_peak_hi: got %h want 24", h); end
        checks++; if (s !== 8'h40) begin errors++; $display("FAIL seed27_view3: got %h want 40", s); end
        repeat (5) @(negedge clk);
        read_views(0, c, l, h, s);
        checks++; if ({c, l, h, s} !== {8'd111, 8'h10, 8'h24, 8'h40}) begin
            errors++; $display("FAIL done_hold: got %h %h %h %h want 6f 10 24 40", c, l, h, s);
        end
    endtask

    task automatic test_edge_seeds;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd1);
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 1) begin errors++; $display("FAIL seed1_edges: got %0d want 1", e); end
        checks++; if (c !== 8'd0 || l !== 8'd1) begin errors++; $display("FAIL seed1_result: got cnt %0d peak %0d want 0 1", c, l); end
        start_pulse(0, 8'd0);
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 1) begin errors++; $display("FAIL seed0_edges: got %0d want 1", e); end
        checks++; if (status_a !== 2'b01 || s !== 8'h50) begin errors++; $display("FAIL seed0_status: got %b view %h want 01 50", status_a, s); end
        checks++; if (c !== 8'd0 || l !== 8'd0) begin errors++; $display("FAIL seed0_result: got cnt %0d peak %0d want 0 0", c, l); end
    endtask

    task automatic test_overflow;
        int e; logic [7:0] c, l, h, s;
        start_pulse(1, 8'd27);
        wait_done(1, e);
        read_views(1, c, l, h, s);
        checks++; if (e !== 12) begin errors++; $display("FAIL ovf_edges: got %0d want 12", e); end
        checks++; if (status_b !== 2'b10 || s !== 8'h60) begin errors++; $display("FAIL ovf_status: got %b view %h want 10 60", status_b, s); end
        checks++; if (c !== 8'd11) begin errors++; $display("FAIL ovf_count: got %0d want 11", c); end
        checks++; if (l !== 8'd214 || h !== 8'd0) begin errors++; $display("FAIL ovf_peak: got %0d hi %0d want 214 0", l, h); end
    endtask

    task automatic test_timeout;
        int e; logic [7:0] c, l, h, s;
        start_pulse(2, 8'd7);
        wait_done(2, e);
        read_views(2, c, l, h, s);
        checks++; if (e !== 16) begin errors++; $display("FAIL tmo_edges: got %0d want 16", e); end
        checks++; if (status_c !== 2'b11 || s !== 8'h70) begin errors++; $display("FAIL tmo_status: got %b view %h want 11 70", status_c, s); end
        checks++; if (c !== 8'd15 || l !== 8'd52) begin errors++; $display("FAIL tmo_result: got cnt %0d peak %0d want 15 52", c, l); end
    endtask

    task automatic test_start_ignored;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd6);
        e = 0;
        while (!done_a && e < 2000) begin
            if (e == 2 || e == 5) begin seed = 8'd27; start_a = 1'b1; end
            else start_a = 1'b0;
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        start_a = 1'b0;
        read_views(0, c, l, h, s);
        checks++; if (e !== 9) begin errors++; $display("FAIL ignore_edges: got %0d want 9", e); end
        checks++; if (c !== 8'd8 || l !== 8'd16) begin errors++; $display("FAIL ignore_result: got cnt %0d peak %0d want 8 16", c, l); end
    endtask

    task automatic test_ena_pause;
        int e; logic [7:0] c, l, h, s, c_hold;
        start_pulse(0, 8'd7);
        e = 0;
        c_hold = 8'd0;
        while (!done_a && e < 2000) begin
            if (e == 4) begin
                sel = 2'd0; #1; c_hold = dout_a;
                ena = 1'b0;
            end
            if (e == 9) begin
                sel = 2'd0; #1;
                checks++; if (dout_a !== c_hold || busy_a !== 1'b1) begin
                    errors++; $display("FAIL pause_freeze: got cnt %0d busy %b want %0d 1", dout_a, busy_a, c_hold);
                end
                ena = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        ena = 1'b1;
        read_views(0, c, l, h, s);
        checks++; if (c_hold !== 8'd4) begin errors++; $display("FAIL pause_count_at_4: got %0d want 4", c_hold); end
        checks++; if (e !== 22) begin errors++; $display("FAIL pause_edges: got %0d want 22", e); end
        checks++; if (c !== 8'd16 || l !== 8'd52) begin errors++; $display("FAIL pause_result: got cnt %0d peak %0d want 16 52", c, l); end
    endtask

    task automatic test_reset_mid_run;
        int e; logic [7:0] c, l, h, s;
        start_pulse(0, 8'd27);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy_a, done_a, status_a} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {busy_a, done_a, status_a}); end
        read_views(0, c, l, h, s);
        checks++; if ({c, l, h, s} !== 32'h0) begin errors++; $display("FAIL rst_mid_views: got %h %h %h %h want zeros", c, l, h, s); end
        @(negedge clk);
        rst_n = 1'b1;
        seed = 8'd6;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_first_start: busy got %b want 1", busy_a); end
        wait_done(0, e);
        read_views(0, c, l, h, s);
        checks++; if (e !== 9 || c !== 8'd8 || l !== 8'd16) begin
            errors++; $display("FAIL rst_fresh_seq: got edges %0d cnt %0d peak %0d want 9 8 16", e, c, l);
        end
    endtask

    initial begin
        test_reset;
        test_seed6;
        test_back_to_back;
        test_seed27;
        test_edge_seeds;
        test_overflow;
        test_timeout;
        test_start_ignored;
        test_ena_pause;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
